// File: rtl/ring_inject_queue.sv
// Buffered injector between a local device and a ring stop injector port.
// Drops packets with no destination and keeps occupancy/drop/stall statistics.
package ring_pkg;
  localparam int DEST_W   = 8;
  localparam int SENDER_W = 8;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic                valid;
    logic [DEST_W-1:0]   dest_vector;
    logic [SENDER_W-1:0] sender_id;
    logic [DATA_W-1:0]   payload;
  } ring_packet;
endpackage

module ring_inject_queue
  import ring_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter bit STAMP_SENDER = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ring_id,
  input  ring_packet             dev_packet,
  input  logic                   dev_issue,
  output logic                   dev_ready,
  output logic                   dev_issuing,
  output ring_packet             inj_packet,
  output logic                   inj_issue,
  input  logic                   inj_ready,
  input  logic                   inj_issuing,
  input  logic                   stats_clear,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       drop_count,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  ring_packet       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             offer;
  logic             do_enq;
  logic             do_drop;
  logic             do_deq;
  ring_packet       enq_packet;
  logic             unused_ok;

  // The stop always accepts when its slot is free, so inj_ready carries no information.
  assign unused_ok = ^{inj_ready, ring_id};

  always_comb begin
    offer       = dev_issue && dev_packet.valid;
    dev_ready   = (occupancy != FULL_OCC);
    dev_issuing = offer && dev_ready && !reset;
    do_drop     = dev_issuing && (dev_packet.dest_vector == '0);
    do_enq      = dev_issuing && (dev_packet.dest_vector != '0);
    inj_issue   = (occupancy != '0);
    do_deq      = inj_issuing && inj_issue;

    enq_packet       = dev_packet;
    enq_packet.valid = 1'b1;
    if (STAMP_SENDER) begin
      enq_packet.sender_id = ring_id[SENDER_W-1:0];
    end

    // Head is taken straight from storage: no bypass of an empty queue.
    inj_packet = inj_issue ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   occupancy <= occupancy + (PTR_W+1)'(1);
        2'b01:   occupancy <= occupancy - (PTR_W+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_packet;
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      drop_count  <= '0;
      stall_count <= '0;
    end else begin
      if (do_drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
      if (inj_issue && !inj_issuing && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ring_inject_queue.sv
// Directed bench for ring_inject_queue: a queue-based model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_ring_inject_queue;
  import ring_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      ring_id;
  ring_packet       dev_packet;
  logic             dev_issue;
  logic             dev_ready;
  logic             dev_issuing;
  ring_packet       inj_packet;
  logic             inj_issue;
  logic             inj_ready;
  logic             inj_issuing;
  logic             stats_clear;
  logic [2:0]       occupancy;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] stall_count;

  int  checks = 0;
  int  errors = 0;
  bit  checking = 1'b0;

  ring_packet model_q[$];
  int         model_drop;
  int         model_stall;

  ring_inject_queue #(.DEPTH(DEPTH), .STAMP_SENDER(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ring_id(ring_id),
    .dev_packet(dev_packet), .dev_issue(dev_issue),
    .dev_ready(dev_ready), .dev_issuing(dev_issuing),
    .inj_packet(inj_packet), .inj_issue(inj_issue),
    .inj_ready(inj_ready), .inj_issuing(inj_issuing),
    .stats_clear(stats_clear), .occupancy(occupancy),
    .drop_count(drop_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic ring_packet mkPkt(input logic [7:0] dest, input logic [7:0] sender,
                                       input logic [31:0] payload);
    ring_packet p;
    p.valid       = 1'b1;
    p.dest_vector = dest;
    p.sender_id   = sender;
    p.payload     = payload;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge and hold through the next edge.
  task automatic applyStimulus(input logic rst, input logic iss, input ring_packet pkt,
                               input logic deq, input logic clr);
    reset       = rst;
    dev_issue   = iss;
    dev_packet  = pkt;
    inj_issuing = deq;
    stats_clear = clr;
    @(posedge clk);
    #1;
  endtask

  // Model: a packet queue plus two saturating counters, advanced at each edge.
  always @(posedge clk) begin : model_update
    bit         ack;
    ring_packet p;
    if (reset) begin
      model_q.delete();
      model_drop  = 0;
      model_stall = 0;
    end else begin
      ack = dev_issue && dev_packet.valid && (model_q.size() < DEPTH);
      if (stats_clear) begin
        model_drop  = 0;
        model_stall = 0;
      end else begin
        if (ack && dev_packet.dest_vector == 8'h00 && model_drop < CNT_MAX) model_drop++;
        if (model_q.size() != 0 && !inj_issuing && model_stall < CNT_MAX) model_stall++;
      end
      if (inj_issuing && model_q.size() != 0) void'(model_q.pop_front());
      if (ack && dev_packet.dest_vector != 8'h00) begin
        p           = dev_packet;
        p.valid     = 1'b1;
        p.sender_id = ring_id[7:0];
        model_q.push_back(p);
      end
    end
  end

  always @(negedge clk) begin : compare
    ring_packet exp_pkt;
    bit         exp_ready;
    if (checking) begin
      exp_ready = (model_q.size() < DEPTH);
      exp_pkt   = (model_q.size() != 0) ? model_q[0] : '0;
      checkOutput("dev_ready", 64'(dev_ready), 64'(exp_ready));
      checkOutput("dev_issuing", 64'(dev_issuing),
                  64'(!reset && dev_issue && dev_packet.valid && exp_ready));
      checkOutput("inj_issue", 64'(inj_issue), 64'(model_q.size() != 0));
      checkOutput("inj_packet", 64'(inj_packet), 64'(exp_pkt));
      checkOutput("occupancy", 64'(occupancy), 64'(model_q.size()));
      checkOutput("drop_count", 64'(drop_count), 64'(model_drop));
      checkOutput("stall_count", 64'(stall_count), 64'(model_stall));
    end
  end

  initial begin
    ring_id     = 32'h0000_0005;
    inj_ready   = 1'b1;
    reset       = 1'b1;
    dev_issue   = 1'b0;
    dev_packet  = '0;
    inj_issuing = 1'b0;
    stats_clear = 1'b0;

    applyStimulus(1, 0, '0, 0, 0);
    checking = 1'b1;
    applyStimulus(1, 0, '0, 0, 0);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_dev_ready", 64'(dev_ready), 64'd1);
    checkOutput("rst_inj_issue", 64'(inj_issue), 64'd0);
    checkOutput("rst_inj_valid", 64'(inj_packet.valid), 64'd0);

    // Single packet waiting three cycles at the head.
    applyStimulus(0, 1, mkPkt(8'h02, 8'h1F, 32'hA0), 0, 0);
    checkOutput("t1_issue_next", 64'(inj_issue), 64'd1);
    repeat (3) applyStimulus(0, 0, '0, 0, 0);
    checkOutput("t1_stall", 64'(stall_count), 64'd3);
    checkOutput("t1_dest", 64'(inj_packet.dest_vector), 64'h02);
    checkOutput("t1_sender", 64'(inj_packet.sender_id), 64'h05);
    checkOutput("t1_payload", 64'(inj_packet.payload), 64'hA0);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("t1_drained", 64'(occupancy), 64'd0);
    checkOutput("t1_cleared", 64'(stall_count), 64'd0);

    // Fill to capacity; the fifth offer must be held off.
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, mkPkt(8'h0F, 8'h1F, 32'hB0 + i), 0, 0);
    checkOutput("t2_occupancy", 64'(occupancy), 64'd4);
    checkOutput("t2_dev_ready", 64'(dev_ready), 64'd0);
    checkOutput("t2_head", 64'(inj_packet.payload), 64'hB1);

    // Dequeue while full: no pass-through, then the offer lands next cycle.
    applyStimulus(0, 1, mkPkt(8'h03, 8'h00, 32'hB5), 1, 0);
    checkOutput("t3_occ_after_deq", 64'(occupancy), 64'd3);
    applyStimulus(0, 1, mkPkt(8'h03, 8'h00, 32'hB5), 0, 0);
    checkOutput("t3_occ_refill", 64'(occupancy), 64'd4);
    checkOutput("t3_head", 64'(inj_packet.payload), 64'hB2);
    repeat (4) applyStimulus(0, 0, '0, 1, 0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t3_empty", 64'(occupancy), 64'd0);

    // Drop filtering and drop counter saturation.
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 1, mkPkt(8'h00, 8'h11, 32'hDEAD), 0, 0);
    checkOutput("t4_drop1", 64'(drop_count), 64'd1);
    checkOutput("t4_no_enq", 64'(occupancy), 64'd0);
    repeat (CNT_MAX + 5) applyStimulus(0, 1, mkPkt(8'h00, 8'h11, 32'hDEAD), 0, 0);
    checkOutput("t4_drop_sat", 64'(drop_count), 64'hFF);
    applyStimulus(0, 1, mkPkt(8'h00, 8'h11, 32'hDEAD), 0, 1);
    checkOutput("t4_clear_wins", 64'(drop_count), 64'd0);

    // Stall counter saturation; clearing leaves the queue untouched.
    applyStimulus(0, 1, mkPkt(8'h01, 8'h22, 32'hC0), 0, 0);
    repeat (CNT_MAX + 5) applyStimulus(0, 0, '0, 0, 0);
    checkOutput("t4_stall_sat", 64'(stall_count), 64'hFF);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("t4_stall_clr", 64'(stall_count), 64'd0);
    checkOutput("t4_fifo_kept", 64'(occupancy), 64'd1);
    applyStimulus(0, 0, '0, 1, 0);

    // Sender stamping and ordering across the pointer wrap.
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, mkPkt(8'h04, 8'h1F, 32'hD0 + i), 0, 0);
    checkOutput("t5_sender", 64'(inj_packet.sender_id), 64'h05);
    checkOutput("t5_first", 64'(inj_packet.payload), 64'hD1);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t5_second", 64'(inj_packet.payload), 64'hD2);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t5_third", 64'(inj_packet.payload), 64'hD3);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t5_empty", 64'(inj_issue), 64'd0);

    // Reset mid-operation flushes the queue and ignores a concurrent offer.
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, mkPkt(8'h08, 8'h00, 32'hE0 + i), 0, 0);
    checkOutput("t6_occ3", 64'(occupancy), 64'd3);
    applyStimulus(1, 1, mkPkt(8'h08, 8'h00, 32'hEE), 0, 0);
    checkOutput("t6_inj_issue", 64'(inj_issue), 64'd0);
    checkOutput("t6_occupancy", 64'(occupancy), 64'd0);
    checkOutput("t6_drop", 64'(drop_count), 64'd0);
    checkOutput("t6_stall", 64'(stall_count), 64'd0);
    checkOutput("t6_dev_ready", 64'(dev_ready), 64'd1);
    repeat (2) applyStimulus(0, 0, '0, 0, 0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
